// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap controller that arbitrates mem-stage exceptions and interrupts, drains the
// pipeline and redirects the PC. Defining TRAP_VECTORED_EN enables vectored interrupt targets.
module trap_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_LOCAL_IRQ = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DATA_WIDTH-1:0]    exception_i,
  input  logic [DATA_WIDTH-1:0]    pc_i,
  input  logic [DATA_WIDTH-1:0]    badaddr_i,
  input  logic                     mstatus_ie_i,
  input  logic                     mie_external_i,
  input  logic                     mie_timer_i,
  input  logic                     mie_sw_i,
  input  logic                     mip_external_i,
  input  logic                     mip_timer_i,
  input  logic                     mip_sw_i,
  input  logic [NUM_LOCAL_IRQ-1:0] mie_local_i,
  input  logic [NUM_LOCAL_IRQ-1:0] mip_local_i,
  input  logic [DATA_WIDTH-1:0]    mtvec_i,
  input  logic [DATA_WIDTH-1:0]    epc_i,
  input  logic                     flush_ack_i,
  output logic                     flush_req_o,
  output logic                     interrupt_type_o,
  output logic [4:0]               trap_cause_o,
  output logic                     cause_we_o,
  output logic                     epc_we_o,
  output logic                     mtval_we_o,
  output logic [DATA_WIDTH-1:0]    epc_o,
  output logic [DATA_WIDTH-1:0]    mtval_o,
  output logic                     mstatus_ie_clear_o,
  output logic                     mstatus_ie_set_o,
  output logic                     interrupt_en_o,
  output logic [DATA_WIDTH-1:0]    new_pc_o
);

  typedef enum logic [2:0] {
    ST_RESET       = 3'd0,
    ST_OPERATING   = 3'd1,
    ST_FLUSH_WAIT  = 3'd2,
    ST_TRAP_TAKEN  = 3'd3,
    ST_TRAP_RETURN = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [4:0]              trap_cause_q, trap_cause_d;
  logic                    interrupt_type_q, interrupt_type_d;
  logic [DATA_WIDTH-1:0]   epc_q, epc_d;
  logic [DATA_WIDTH-1:0]   mtval_q, mtval_d;

  logic                     exc_pending_s;
  logic                     exc_has_tval_s;
  logic [4:0]               exc_cause_s;
  logic                     irq_pending_s;
  logic [4:0]               irq_cause_s;
  logic [NUM_LOCAL_IRQ-1:0] local_act_s;
  logic [DATA_WIDTH-1:0]    base_s;
  logic [DATA_WIDTH-1:0]    target_s;
  logic                     unused_s;

  // Bits of exception_i above the defined strobes carry no meaning here.
  assign unused_s      = &{1'b0, exception_i[DATA_WIDTH-1:6], mtvec_i[1:0]};
  assign exc_pending_s = |exception_i[5:1];
  assign local_act_s   = mie_local_i & mip_local_i;
  assign irq_pending_s = mstatus_ie_i & ((mie_external_i & mip_external_i) |
                                         (mie_sw_i & mip_sw_i) |
                                         (mie_timer_i & mip_timer_i) |
                                         (|local_act_s));

  // Exception cause selection in fixed priority order
  always_comb begin
    exc_cause_s    = 5'd0;
    exc_has_tval_s = 1'b0;
    if (exception_i[3]) begin
      exc_cause_s    = 5'd2;
      exc_has_tval_s = 1'b1;
    end else if (exception_i[2]) begin
      exc_cause_s = 5'd3;
    end else if (exception_i[1]) begin
      exc_cause_s = 5'd11;
    end else if (exception_i[4]) begin
      exc_cause_s    = 5'd4;
      exc_has_tval_s = 1'b1;
    end else if (exception_i[5]) begin
      exc_cause_s    = 5'd6;
      exc_has_tval_s = 1'b1;
    end else begin
      exc_cause_s    = 5'd0;
      exc_has_tval_s = 1'b0;
    end
  end

  // Interrupt cause selection; local lines scanned downward so the lowest index wins
  always_comb begin
    irq_cause_s = 5'd0;
    if (mie_external_i & mip_external_i) begin
      irq_cause_s = 5'd11;
    end else if (mie_sw_i & mip_sw_i) begin
      irq_cause_s = 5'd3;
    end else if (mie_timer_i & mip_timer_i) begin
      irq_cause_s = 5'd7;
    end else begin
      for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
        if (local_act_s[i]) begin
          irq_cause_s = 5'(16 + i);
        end else begin
          irq_cause_s = irq_cause_s;
        end
      end
    end
  end

  // Handler address from the live mtvec and the latched trap
  always_comb begin
    base_s   = {mtvec_i[DATA_WIDTH-1:2], 2'b00};
    target_s = base_s;
`ifdef TRAP_VECTORED_EN
    if (interrupt_type_q && (mtvec_i[1:0] == 2'b01)) begin
      target_s = base_s + {{(DATA_WIDTH-7){1'b0}}, trap_cause_q, 2'b00};
    end else begin
      target_s = base_s;
    end
`endif
  end

  // Next-state logic, trap latching and CSR strobes
  always_comb begin
    state_d            = state_q;
    trap_cause_d       = trap_cause_q;
    interrupt_type_d   = interrupt_type_q;
    epc_d              = epc_q;
    mtval_d            = mtval_q;
    flush_req_o        = 1'b0;
    interrupt_en_o     = 1'b0;
    epc_we_o           = 1'b0;
    cause_we_o         = 1'b0;
    mtval_we_o         = 1'b0;
    mstatus_ie_clear_o = 1'b0;
    mstatus_ie_set_o   = 1'b0;
    new_pc_o           = {DATA_WIDTH{1'b0}};
    case (state_q)
      ST_RESET: state_d = ST_OPERATING;
      ST_OPERATING: begin
        if (exc_pending_s) begin
          trap_cause_d     = exc_cause_s;
          interrupt_type_d = 1'b0;
          epc_d            = pc_i;
          mtval_d          = exc_has_tval_s ? badaddr_i : {DATA_WIDTH{1'b0}};
          state_d          = ST_FLUSH_WAIT;
        end else if (irq_pending_s) begin
          trap_cause_d     = irq_cause_s;
          interrupt_type_d = 1'b1;
          epc_d            = pc_i;
          mtval_d          = {DATA_WIDTH{1'b0}};
          state_d          = ST_FLUSH_WAIT;
        end else if (exception_i[0]) begin
          state_d = ST_TRAP_RETURN;
        end else begin
          state_d = ST_OPERATING;
        end
      end
      ST_FLUSH_WAIT: begin
        flush_req_o = 1'b1;
        if (flush_ack_i) begin
          state_d = ST_TRAP_TAKEN;
        end else begin
          state_d = ST_FLUSH_WAIT;
        end
      end
      ST_TRAP_TAKEN: begin
        interrupt_en_o     = 1'b1;
        epc_we_o           = 1'b1;
        cause_we_o         = 1'b1;
        mstatus_ie_clear_o = 1'b1;
        mtval_we_o         = ~interrupt_type_q;
        new_pc_o           = target_s;
        state_d            = ST_OPERATING;
      end
      ST_TRAP_RETURN: begin
        interrupt_en_o   = 1'b1;
        mstatus_ie_set_o = 1'b1;
        new_pc_o         = epc_i;
        state_d          = ST_OPERATING;
      end
      default: state_d = ST_RESET;
    endcase
  end

  // State and latched-trap registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= ST_RESET;
      trap_cause_q     <= 5'd0;
      interrupt_type_q <= 1'b0;
      epc_q            <= {DATA_WIDTH{1'b0}};
      mtval_q          <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q          <= state_d;
      trap_cause_q     <= trap_cause_d;
      interrupt_type_q <= interrupt_type_d;
      epc_q            <= epc_d;
      mtval_q          <= mtval_d;
    end
  end

  assign trap_cause_o     = trap_cause_q;
  assign interrupt_type_o = interrupt_type_q;
  assign epc_o            = epc_q;
  assign mtval_o          = mtval_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus pushes reference-model predictions, a negedge monitor
// pops and checks them whenever any redirect/CSR strobe is seen.
module tb_trap_ctrl;
  localparam int DW = 32;
  localparam int NL = 4;
  localparam int EXC_BIT  [5] = '{3, 2, 1, 4, 5};
  localparam int EXC_CODE [5] = '{2, 3, 11, 4, 6};

  typedef struct {
    logic        is_ret;
    logic [4:0]  cause;
    logic        itype;
    logic [31:0] epc;
    logic [31:0] mtval;
    logic [31:0] new_pc;
    int          cyc;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [DW-1:0] exception_i = '0, pc_i = '0, badaddr_i = '0, mtvec_i = '0, epc_i = '0;
  logic mstatus_ie_i = 1'b0, mie_external_i = 1'b0, mie_timer_i = 1'b0, mie_sw_i = 1'b0;
  logic mip_external_i = 1'b0, mip_timer_i = 1'b0, mip_sw_i = 1'b0, flush_ack_i = 1'b0;
  logic [NL-1:0] mie_local_i = '0, mip_local_i = '0;
  logic flush_req_o, interrupt_type_o, cause_we_o, epc_we_o, mtval_we_o;
  logic mstatus_ie_clear_o, mstatus_ie_set_o, interrupt_en_o;
  logic [4:0] trap_cause_o;
  logic [DW-1:0] epc_o, mtval_o, new_pc_o;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  exp_t sbq[$];

  trap_ctrl #(.DATA_WIDTH(DW), .NUM_LOCAL_IRQ(NL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .exception_i(exception_i), .pc_i(pc_i), .badaddr_i(badaddr_i),
    .mstatus_ie_i(mstatus_ie_i), .mie_external_i(mie_external_i), .mie_timer_i(mie_timer_i),
    .mie_sw_i(mie_sw_i), .mip_external_i(mip_external_i), .mip_timer_i(mip_timer_i),
    .mip_sw_i(mip_sw_i), .mie_local_i(mie_local_i), .mip_local_i(mip_local_i),
    .mtvec_i(mtvec_i), .epc_i(epc_i), .flush_ack_i(flush_ack_i), .flush_req_o(flush_req_o),
    .interrupt_type_o(interrupt_type_o), .trap_cause_o(trap_cause_o), .cause_we_o(cause_we_o),
    .epc_we_o(epc_we_o), .mtval_we_o(mtval_we_o), .epc_o(epc_o), .mtval_o(mtval_o),
    .mstatus_ie_clear_o(mstatus_ie_clear_o), .mstatus_ie_set_o(mstatus_ie_set_o),
    .interrupt_en_o(interrupt_en_o), .new_pc_o(new_pc_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_pending();
    exception_i = '0;
    mip_external_i = 1'b0; mip_timer_i = 1'b0; mip_sw_i = 1'b0; mip_local_i = '0;
  endtask

  task automatic clear_all();
    clear_pending();
    mstatus_ie_i = 1'b0; mie_external_i = 1'b0; mie_timer_i = 1'b0; mie_sw_i = 1'b0;
    mie_local_i = '0;
  endtask

  // Reference: kind 0 = nothing, 1 = trap, 2 = mret; built from the priority tables.
  function automatic void model(output exp_t e, output int kind);
    int   codes[$];
    bit   act[$];
    logic [31:0] base;
    e = '{is_ret: 1'b0, cause: 5'd0, itype: 1'b0, epc: 32'd0, mtval: 32'd0, new_pc: 32'd0, cyc: 0};
    kind = 0;
    for (int i = 0; i < 5; i++) begin
      if (kind == 0 && exception_i[EXC_BIT[i]]) begin
        kind  = 1;
        e.cause = 5'(EXC_CODE[i]);
        e.mtval = (EXC_CODE[i] == 2 || EXC_CODE[i] == 4 || EXC_CODE[i] == 6) ? badaddr_i : 32'd0;
      end
    end
    if (kind == 0 && mstatus_ie_i) begin
      act.push_back(mie_external_i & mip_external_i); codes.push_back(11);
      act.push_back(mie_sw_i & mip_sw_i);             codes.push_back(3);
      act.push_back(mie_timer_i & mip_timer_i);       codes.push_back(7);
      for (int i = 0; i < NL; i++) begin
        act.push_back(mie_local_i[i] & mip_local_i[i]); codes.push_back(16 + i);
      end
      for (int i = 0; i < codes.size(); i++) begin
        if (kind == 0 && act[i]) begin
          kind = 1; e.itype = 1'b1; e.cause = 5'(codes[i]);
        end
      end
    end
    if (kind == 0 && exception_i[0]) begin
      kind = 2; e.is_ret = 1'b1; e.new_pc = epc_i;
    end
    if (kind == 1) begin
      e.epc = pc_i;
      base  = mtvec_i & ~32'd3;
      e.new_pc = base;
`ifdef TRAP_VECTORED_EN
      if (e.itype && mtvec_i[1:0] == 2'b01) e.new_pc = base + 32'(e.cause) * 32'd4;
`endif
    end
  endfunction

  // Present the currently driven inputs, hold flush_ack low for d cycles, then let the trap complete.
  task automatic issue(input int d);
    exp_t e;
    int   kind;
    model(e, kind);
    e.cyc = cyc + ((kind == 2) ? 1 : 2 + d);
    if (kind != 0) sbq.push_back(e);
    flush_ack_i = (d == 0);
    step();
    clear_pending();
    if (kind == 1) begin
      for (int j = 0; j < d; j++) begin
        chk("flush_req_wait", 32'(flush_req_o), 32'd1);
        chk("cause_held", 32'(trap_cause_o), 32'(e.cause));
        chk("type_held", 32'(interrupt_type_o), 32'(e.itype));
        mip_external_i = 1'($urandom); mip_timer_i = 1'($urandom); mip_sw_i = 1'($urandom);
        mip_local_i = NL'($urandom); exception_i = $urandom;
        step();
      end
      chk("flush_req", 32'(flush_req_o), 32'd1);
      clear_pending();
      flush_ack_i = 1'b1;
      step();
      flush_ack_i = 1'b0;
      step();
    end else if (kind == 2) begin
      step();
    end else begin
      chk("idle_flush_req", 32'(flush_req_o), 32'd0);
    end
    chk("drain", 32'(sbq.size()), 32'd0);
    while (sbq.size() > 0) void'(sbq.pop_front());
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flush_req"}, 32'(flush_req_o), 32'd0);
    chk({tag, "_int_en"}, 32'(interrupt_en_o), 32'd0);
    chk({tag, "_cause"}, 32'(trap_cause_o), 32'd0);
    chk({tag, "_itype"}, 32'(interrupt_type_o), 32'd0);
    chk({tag, "_epc"}, epc_o, 32'd0);
    chk({tag, "_mtval"}, mtval_o, 32'd0);
    chk({tag, "_new_pc"}, new_pc_o, 32'd0);
    chk({tag, "_strobes"}, 32'({epc_we_o, cause_we_o, mtval_we_o, mstatus_ie_clear_o, mstatus_ie_set_o}), 32'd0);
  endtask

  // Monitor: every strobe cycle must match the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (interrupt_en_o | epc_we_o | cause_we_o | mtval_we_o | mstatus_ie_set_o | mstatus_ie_clear_o) begin
        if (sbq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_strobe: got int_en=%b epc_we=%b cause_we=%b expected none (cycle %0d)",
                   interrupt_en_o, epc_we_o, cause_we_o, cyc);
        end else begin
          e = sbq.pop_front();
          chk("redirect_cycle", 32'(cyc), 32'(e.cyc));
          chk("int_en", 32'(interrupt_en_o), 32'd1);
          chk("new_pc", new_pc_o, e.new_pc);
          chk("ie_set", 32'(mstatus_ie_set_o), 32'(e.is_ret));
          chk("ie_clear", 32'(mstatus_ie_clear_o), 32'(!e.is_ret));
          chk("epc_we", 32'(epc_we_o), 32'(!e.is_ret));
          chk("cause_we", 32'(cause_we_o), 32'(!e.is_ret));
          chk("mtval_we", 32'(mtval_we_o), 32'(!e.is_ret && !e.itype));
          if (!e.is_ret) begin
            chk("cause", 32'(trap_cause_o), 32'(e.cause));
            chk("itype", 32'(interrupt_type_o), 32'(e.itype));
            chk("epc", epc_o, e.epc);
            chk("mtval", mtval_o, e.mtval);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mode;
    repeat (3) step();
    chk_all_zero("reset");
    rst_i = 1'b0;
    step();

    // Timer interrupt, mtvec in vectored mode
    clear_all();
    mstatus_ie_i = 1'b1; mie_timer_i = 1'b1; mip_timer_i = 1'b1;
    pc_i = 32'h100; mtvec_i = 32'h201;
    issue(0);

    // Illegal instruction
    clear_all();
    exception_i = 32'h8; badaddr_i = 32'hDEADBEEF; mtvec_i = 32'h300; pc_i = 32'h400;
    issue(0);

    // Exception beats simultaneous interrupts, then MEI wins among interrupts
    clear_all();
    mstatus_ie_i = 1'b1;
    mie_external_i = 1'b1; mip_external_i = 1'b1; mie_timer_i = 1'b1; mip_timer_i = 1'b1;
    mie_local_i = 4'b0100; mip_local_i = 4'b0100; exception_i = 32'h2; mtvec_i = 32'h1001;
    issue(1);
    mip_external_i = 1'b1; mip_timer_i = 1'b1; mip_local_i = 4'b0100;
    issue(0);

    // Local-only, lowest index first
    clear_all();
    mstatus_ie_i = 1'b1; mie_local_i = 4'hF; mip_local_i = 4'b1010; mtvec_i = 32'h2001;
    issue(0);

    // Long flush wait with changing pending bits
    clear_all();
    mstatus_ie_i = 1'b1; mie_sw_i = 1'b1; mip_sw_i = 1'b1; mie_external_i = 1'b1;
    mie_timer_i = 1'b1; mie_local_i = 4'hF;
    issue(5);

    // mret
    clear_all();
    exception_i = 32'h1; epc_i = 32'h1234;
    issue(0);

    // Reset in the middle of a flush
    clear_all();
    exception_i = 32'h10; badaddr_i = 32'h55; flush_ack_i = 1'b0;
    step();
    chk("rst_flush_req_before", 32'(flush_req_o), 32'd1);
    clear_pending();
    rst_i = 1'b1; flush_ack_i = 1'b1;
    step();
    chk_all_zero("midflush");
    rst_i = 1'b0; flush_ack_i = 1'b0;
    step();
    exception_i = 32'h20; badaddr_i = 32'h77; pc_i = 32'h88; mtvec_i = 32'h500;
    issue(2);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      clear_all();
      mode = $urandom_range(0, 3);
      case (mode)
        0: exception_i = '0;
        1: exception_i = 32'd1 << $urandom_range(0, 5);
        2: exception_i = $urandom & 32'h3F;
        default: exception_i = $urandom;
      endcase
      mstatus_ie_i = 1'($urandom);
      mie_external_i = 1'($urandom); mie_timer_i = 1'($urandom); mie_sw_i = 1'($urandom);
      mip_external_i = 1'($urandom); mip_timer_i = 1'($urandom); mip_sw_i = 1'($urandom);
      mie_local_i = NL'($urandom); mip_local_i = NL'($urandom);
      pc_i = $urandom; badaddr_i = $urandom; epc_i = $urandom;
      mtvec_i = $urandom;
      issue($urandom_range(0, 4));
    end

    clear_all();
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
